// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor.
// One BITS_PER_CYCLE-wide adder stage plus a registered carry walks the
// operands LSB-first over WIDTH/BITS_PER_CYCLE cycles. Subtraction is done by
// adding the inverted B operand with an inverted carry-in.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_count;
  logic                      r_carry;
  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [WIDTH-1:0]          r_sum;
  logic                      r_cout;
  logic                      r_ovf;
  logic                      r_inReady;
  logic                      r_outValid;

  logic [BITS_PER_CYCLE-1:0] w_aDigit;
  logic [BITS_PER_CYCLE-1:0] w_bDigit;
  logic [BITS_PER_CYCLE:0]   w_digitAdd;
  logic                      w_msbCarryIn;

  // Select the current digit of both captured operands.
  always_comb begin
    w_aDigit = '0;
    w_bDigit = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (r_count == CW'(i)) begin
        w_aDigit = r_a[i*BITS_PER_CYCLE +: BITS_PER_CYCLE];
        w_bDigit = r_b[i*BITS_PER_CYCLE +: BITS_PER_CYCLE];
      end
    end
  end

  // The single shared digit adder; top bit is the digit carry-out.
  assign w_digitAdd = {1'b0, w_aDigit} + {1'b0, w_bDigit}
                    + {{BITS_PER_CYCLE{1'b0}}, r_carry};

  // Carry into the digit MSB recovered from its operand and sum bits.
  assign w_msbCarryIn = w_aDigit[BITS_PER_CYCLE-1] ^ w_bDigit[BITS_PER_CYCLE-1]
                      ^ w_digitAdd[BITS_PER_CYCLE-1];

  // Control FSM and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= A;
            r_b       <= Sub ? ~B : B;
            r_carry   <= Cin ^ Sub;
            r_count   <= '0;
            r_state   <= RUN;
            r_inReady <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < STEPS; i++) begin
            if (r_count == CW'(i)) begin
              r_sum[i*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= w_digitAdd[BITS_PER_CYCLE-1:0];
            end
          end
          r_carry <= w_digitAdd[BITS_PER_CYCLE];
          if (r_count == LAST) begin
            r_count    <= '0;
            r_cout     <= w_digitAdd[BITS_PER_CYCLE];
            r_ovf      <= w_msbCarryIn ^ w_digitAdd[BITS_PER_CYCLE];
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_count    <= '0;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder.
// Two instances run side by side: index 0 is 8-bit with one bit per cycle,
// index 1 is 8-bit with four bits per cycle. Expected results come from a
// plain-arithmetic model and are queued at acceptance; monitors pop them
// when each instance completes a result handshake.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid  [2];
  logic       inReady  [2];
  logic       outValid [2];
  logic       outReady [2];
  logic [7:0] opA      [2];
  logic [7:0] opB      [2];
  logic       cin      [2];
  logic       sub      [2];
  logic [7:0] sum      [2];
  logic       cout     [2];
  logic       ovf      [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon0;
  exp_t mon1;
  int   checks   = 0;
  int   failures = 0;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .A(opA[0]), .B(opB[0]), .Cin(cin[0]), .Sub(sub[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .Sum(sum[0]), .Cout(cout[0]), .Ovf(ovf[0])
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .A(opA[1]), .B(opB[1]), .Cin(cin[1]), .Sub(sub[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .Sum(sum[1]), .Cout(cout[1]), .Ovf(ovf[1])
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference: signed and unsigned arithmetic on plain integers.
  function automatic exp_t model(input int a, input int b, input int c, input int s);
    exp_t r;
    int   u;
    int   sv;
    int   sa;
    int   sb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    if (s == 0) begin
      u      = a + b + c;
      sv     = sa + sb + c;
      r.cout = (u >= 256);
    end else begin
      u      = a - b - c;
      sv     = sa - sb - c;
      r.cout = (u >= 0);
    end
    r.sum = u[7:0];
    r.ovf = (sv > 127) || (sv < -128);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor for the bit-serial instance: pop and compare on each handshake.
  always @(negedge clk) begin
    if (rst_n && outValid[0] && outReady[0]) begin
      if (q0.size() == 0) begin
        checkOutput("unexpected0", 32'd1, 32'd0);
      end else begin
        mon0 = q0.pop_front();
        checkOutput("sum0",  sum[0],  mon0.sum);
        checkOutput("cout0", cout[0], mon0.cout);
        checkOutput("ovf0",  ovf[0],  mon0.ovf);
      end
    end
  end

  // Monitor for the four-bit-digit instance.
  always @(negedge clk) begin
    if (rst_n && outValid[1] && outReady[1]) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected1", 32'd1, 32'd0);
      end else begin
        mon1 = q1.pop_front();
        checkOutput("sum1",  sum[1],  mon1.sum);
        checkOutput("cout1", cout[1], mon1.cout);
        checkOutput("ovf1",  ovf[1],  mon1.ovf);
      end
    end
  end

  // Issue one operation and return cycles from accept to first out_valid.
  task automatic applyStimulus(input int k, input int a, input int b, input int c,
                               input int s, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!inReady[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inReadyBeforeIssue", inReady[k], 1);
    inValid[k] = 1'b1;
    opA[k]     = 8'(a);
    opB[k]     = 8'(b);
    cin[k]     = c[0];
    sub[k]     = s[0];
    @(posedge clk);
    if (k == 0) q0.push_back(model(a, b, c, s));
    else        q1.push_back(model(a, b, c, s));
    #1;
    inValid[k] = 1'b0;
    opA[k]     = 8'($urandom);
    opB[k]     = 8'($urandom);
    cin[k]     = 1'($urandom);
    sub[k]     = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!outValid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int   lat;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      inValid[k]  = 1'b0;
      outReady[k] = 1'b1;
      opA[k]      = '0;
      opB[k]      = '0;
      cin[k]      = 1'b0;
      sub[k]      = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput("resetSum",      sum[k],      0);
      checkOutput("resetCout",     cout[k],     0);
      checkOutput("resetOvf",      ovf[k],      0);
      checkOutput("resetOutValid", outValid[k], 0);
      checkOutput("resetInReady",  inReady[k],  1);
    end
    rst_n = 1'b1;

    $display("[TB] directed add/sub cases");
    applyStimulus(0, 8'hFF, 8'h01, 0, 0, lat);
    checkOutput("latencyBpc1", lat, 9);
    applyStimulus(0, 8'h7F, 8'h01, 0, 0, lat);
    applyStimulus(0, 8'h80, 8'h80, 0, 0, lat);
    applyStimulus(0, 8'h05, 8'h07, 0, 1, lat);
    applyStimulus(0, 8'h07, 8'h05, 1, 1, lat);
    applyStimulus(1, 8'hA5, 8'h5A, 1, 0, lat);
    checkOutput("latencyBpc4", lat, 3);

    $display("[TB] backpressure in DONE");
    @(posedge clk); #1 outReady[0] = 1'b0;
    e = model(8'h3C, 8'h99, 0, 1);
    applyStimulus(0, 8'h3C, 8'h99, 0, 1, lat);
    checkOutput("latencyStall", lat, 9);
    for (int i = 0; i < 5; i++) begin
      inValid[0] = ~inValid[0];
      opA[0]     = 8'($urandom);
      opB[0]     = 8'($urandom);
      @(negedge clk);
      checkOutput("stallSum",      sum[0],      e.sum);
      checkOutput("stallCout",     cout[0],     e.cout);
      checkOutput("stallOvf",      ovf[0],      e.ovf);
      checkOutput("stallInReady",  inReady[0],  0);
      checkOutput("stallOutValid", outValid[0], 1);
    end
    inValid[0] = 1'b0;
    @(posedge clk); #1 outReady[0] = 1'b1;
    @(negedge clk);
    checkOutput("inReadyDuringRelease", inReady[0], 0);
    @(negedge clk);
    checkOutput("inReadyAfterRelease", inReady[0], 1);
    @(negedge clk);
    checkOutput("noCaptureWhileIdle", inReady[0], 1);

    $display("[TB] reset in the middle of RUN");
    @(negedge clk);
    inValid[0] = 1'b1;
    opA[0]     = 8'hFF;
    opB[0]     = 8'hFF;
    cin[0]     = 1'b0;
    sub[0]     = 1'b0;
    @(posedge clk); #1 inValid[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortSum",      sum[0],      0);
    checkOutput("abortCout",     cout[0],     0);
    checkOutput("abortOvf",      ovf[0],      0);
    checkOutput("abortOutValid", outValid[0], 0);
    checkOutput("abortInReady",  inReady[0],  1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'h12, 8'h34, 0, 0, lat);
    checkOutput("latencyAfterAbort", lat, 9);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      int  k;
      bit  stall;
      k     = i % 2;
      stall = ($urandom_range(0, 2) == 0);
      if (stall) begin
        @(posedge clk); #1 outReady[k] = 1'b0;
      end
      applyStimulus(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), lat);
      checkOutput("latencyRandom", lat, (k == 0) ? 9 : 3);
      if (stall) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        @(posedge clk); #1 outReady[k] = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("queue0Drained", q0.size(), 0);
    checkOutput("queue1Drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands using a single BITS_PER_CYCLE-wide full-adder stage plus a registered carry, processing digits LSB-first over WIDTH/BITS_PER_CYCLE cycles. It is the area-lean, multi-cycle successor to the single-bit full adder in the arithmetic circuits library. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake, so the block drops into streaming datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, digit width processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/BITS_PER_CYCLE.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (subtract).
- Sub  input  1  0: A+B+Cin; 1: A−B−Cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  add: carry-out; subtract: 1 = no borrow, 0 = borrow.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, capture A and B (B bitwise-inverted when Sub=1), carry register ← Cin ^ Sub, step counter ← 0, go to RUN. Otherwise hold.
- RUN: each cycle, add digit[count] of captured A, digit[count] of captured B, and the carry register. Write the BITS_PER_CYCLE-bit result into Sum digit[count]. Update the carry register with the digit carry-out. Increment the counter. On the edge processing digit STEPS−1, go to DONE, latch Cout = final carry, and set Ovf = carry into the MSB XOR carry out of the MSB.
- DONE: Sum, Cout and Ovf are held stable. On out_ready, go to IDLE.
- Subtract identity: A + ~B + (1 ^ Cin) = A − B − Cin (mod 2^WIDTH).
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Reset: asynchronous, and aborts any operation immediately. state = IDLE, counter = 0, carry = 0, Sum = 0, Cout = 0, Ovf = 0, out_valid = 0, in_ready = 1. No partial result is ever presented.

## Timing
- Acceptance edge E0. Digits are processed on edges E1..E_STEPS. out_valid is high from the cycle after E_STEPS. Latency is STEPS+1 cycles from the accept cycle to the first out_valid cycle.
- Result handshake completes on the edge where out_valid && out_ready. in_ready rises in the following cycle.
- No overlap: minimum initiation interval is STEPS+2 cycles.
- Sum, Cout and Ovf are registered outputs. They change only on RUN edges and reset, and are unchanged throughout DONE regardless of out_ready stalls.
- Counter wraps only by leaving RUN; count == STEPS−1 is the terminal digit.
- BITS_PER_CYCLE = WIDTH is legal: STEPS = 1, and the result is valid 2 cycles after the accept cycle.

## Test plan
- WIDTH=8, BPC=1: A=8'hFF, B=8'h01, Cin=0, Sub=0 -> Sum=8'h00, Cout=1, Ovf=0; out_valid first high 9 cycles after the accept cycle.
- WIDTH=8, BPC=1: A=8'h7F, B=8'h01, Cin=0, Sub=0 -> Sum=8'h80, Cout=0, Ovf=1. Then A=8'h80, B=8'h80 -> Sum=8'h00, Cout=1, Ovf=1.
- WIDTH=8, BPC=1, Sub=1: A=8'h05, B=8'h07, Cin=0 -> Sum=8'hFE, Cout=0 (borrow), Ovf=0. Then A=8'h07, B=8'h05, Cin=1 -> Sum=8'h01, Cout=1.
- WIDTH=8, BPC=4: A=8'hA5, B=8'h5A, Cin=1, Sub=0 -> Sum=8'h00, Cout=1, Ovf=0; out_valid high 3 cycles after the accept cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operand inputs -> Sum/Cout/Ovf unchanged, in_ready=0, no new capture. Raise out_ready -> in_ready=1 the next cycle.
- Reset mid-RUN (assert rst_n=0 off-edge at step 3) -> outputs go to zero and in_ready=1 immediately. After release, a new operation 8'h12+8'h34 yields 8'h46 with no residue from the aborted operation.
